uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 89 ++++++++
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter slice:
//   - default CLK_HZ / BAUD / DEPTH constants
//   - transmitter state enumeration
//   - calc_div(): bit period in clock cycles, rounded to nearest
package uart_pkg;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;
    localparam int unsigned DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // round(clk_hz / baud) using integer arithmetic
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Synchronous DEPTH x 8 FIFO with registered full/empty flags.
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset (empties the FIFO)
//   wr_en_i     write request; ignored while full
//   wr_data_i   byte to store
//   rd_en_i     pop request; ignored while empty
//   rd_data_o   byte at the head of the FIFO (valid while not empty)
//   full_o      registered, count == DEPTH
//   empty_o     registered, count == 0
//   count_o     number of stored bytes, log2(DEPTH)+1 bits
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_wr;
    logic          do_rd;

    // Acceptance uses the registered flags, so a write while full is
    // dropped even when a pop happens in the same cycle.
    assign do_wr = wr_en_i && !full_q;
    assign do_rd = rd_en_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage has no reset; reset empties the FIFO through the pointers.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// FIFO-buffered 8N1 UART transmitter, LSB first, line idles high.
// Ports:
//   SYS_CLK   system clock, all logic on the rising edge
//   rst       asynchronous active-high reset; aborts any frame
//   wr_en     write strobe, one byte per cycle accepted while not full
//   wr_data   byte to queue, sampled only when wr_en=1
//   full      FIFO holds DEPTH bytes (registered)
//   busy      frame in progress or bytes queued (registered)
//   wr_err    sticky: a write was dropped because the FIFO was full
//   ur_tx     registered serial output
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic       SYS_CLK,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       wr_err,
    output logic       ur_tx
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    uart_state_e      state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             ur_tx_q;
    logic             busy_q;
    logic             wr_err_q;

    logic             fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;
    logic [AW:0]      fifo_count;
    logic             bit_end;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (SYS_CLK),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Last cycle of the current bit period.
    assign bit_end = (baud_cnt_q == DIV_LAST);

    // Pop whenever a new frame can start: from IDLE, or at the end of a
    // stop bit so that back-to-back frames have no gap.
    assign fifo_rd = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    // The line register follows the state one cycle later, which gives the
    // two-cycle write-to-start latency and keeps every level exactly DIV
    // cycles long. busy is delayed the same way, so it drops exactly when
    // the last stop bit ends on the line.
    always_ff @(posedge SYS_CLK or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ur_tx_q    <= 1'b1;
            busy_q     <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            if (wr_en && fifo_full) begin
                wr_err_q <= 1'b1;
            end

            busy_q <= (state_q != IDLE) || (fifo_count != '0);

            case (state_q)
                START:   ur_tx_q <= 1'b0;
                DATA:    ur_tx_q <= shift_q[0];
                default: ur_tx_q <= 1'b1;
            endcase

            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    if (fifo_rd) begin
                        shift_q <= fifo_rd_data;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (fifo_rd) begin
                            shift_q <= fifo_rd_data;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign full   = fifo_full;
    assign busy   = busy_q;
    assign wr_err = wr_err_q;
    assign ur_tx  = ur_tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Three transmitter instances share one 50 MHz clock:
//   A: defaults (bit period 434) - exact waveform, latency and reset checks
//   B: 24 MHz / 9600 override (bit period 2500)
//   C: 1 MHz / 100 kbaud (bit period 10) - FIFO full/overflow, order and
//      randomized bursts, decoded by a line receiver against a byte queue
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned DIV_A = (50_000_000 + 115_200 / 2) / 115_200;
    localparam int unsigned DIV_B = (24_000_000 + 9_600 / 2) / 9_600;
    localparam int unsigned DIV_C = (1_000_000 + 100_000 / 2) / 100_000;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, wr_en_a, full_a, busy_a, wr_err_a, tx_a;
    logic [7:0] wr_data_a;
    logic       rst_b, wr_en_b, full_b, busy_b, wr_err_b, tx_b;
    logic [7:0] wr_data_b;
    logic       rst_c, wr_en_c, full_c, busy_c, wr_err_c, tx_c;
    logic [7:0] wr_data_c;

    uart_tx u_dut_a (
        .SYS_CLK (clk), .rst (rst_a), .wr_en (wr_en_a), .wr_data (wr_data_a),
        .full (full_a), .busy (busy_a), .wr_err (wr_err_a), .ur_tx (tx_a)
    );

    uart_tx #(.CLK_HZ(24_000_000), .BAUD(9_600)) u_dut_b (
        .SYS_CLK (clk), .rst (rst_b), .wr_en (wr_en_b), .wr_data (wr_data_b),
        .full (full_b), .busy (busy_b), .wr_err (wr_err_b), .ur_tx (tx_b)
    );

    uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DEPTH(DEPTH)) u_dut_c (
        .SYS_CLK (clk), .rst (rst_c), .wr_en (wr_en_c), .wr_data (wr_data_c),
        .full (full_c), .busy (busy_c), .wr_err (wr_err_c), .ur_tx (tx_c)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic line_of(input int d);
        case (d)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input int d, input logic [7:0] b);
        @(negedge clk);
        case (d)
            0:       begin wr_en_a = 1'b1; wr_data_a = b; end
            1:       begin wr_en_b = 1'b1; wr_data_b = b; end
            default: begin wr_en_c = 1'b1; wr_data_c = b; end
        endcase
        step();
        wr_en_a = 1'b0; wr_data_a = 'x;
        wr_en_b = 1'b0; wr_data_b = 'x;
        wr_en_c = 1'b0; wr_data_c = 'x;
    endtask

    task automatic wait_line(input int d, input logic v, input int unsigned lim,
                             output int unsigned n);
        n = 0;
        while (line_of(d) !== v && n < lim) begin
            step();
            n++;
        end
    endtask

    task automatic run_len(input int d, input int unsigned lim, output int unsigned n);
        logic v;
        v = line_of(d);
        n = 0;
        while (line_of(d) === v && n < lim) begin
            step();
            n++;
        end
    endtask

    // Called at the first sample showing the start bit; samples mid-bit.
    task automatic rx_frame(input int d, input int unsigned div,
                            output logic [7:0] b, output logic ok);
        logic st;
        b = '0;
        repeat (div / 2) step();
        st = line_of(d);
        for (int k = 0; k < 8; k++) begin
            repeat (div) step();
            b[k] = line_of(d);
        end
        repeat (div) step();
        ok = (st === 1'b0) && (line_of(d) === 1'b1);
    endtask

    task automatic wait_idle_a(input int unsigned lim, output int unsigned n);
        n = 0;
        while (busy_a !== 1'b0 && n < lim) begin
            step();
            n++;
        end
    endtask

    // Line receiver for instance C: decodes every frame into rx_q.
    logic [7:0]  rx_q[$];
    int unsigned falls_c     = 0;
    int unsigned last_fall_c = 0;
    int unsigned ferr_c      = 0;
    logic        prev_c      = 1'b1;

    always begin : rx_mon_c
        logic [7:0] b;
        logic       st;
        @(negedge clk);
        if (rst_c === 1'b0 && prev_c === 1'b1 && tx_c === 1'b0) begin
            falls_c++;
            last_fall_c = cyc;
            repeat (DIV_C / 2) @(negedge clk);
            st = tx_c;
            for (int k = 0; k < 8; k++) begin
                repeat (DIV_C) @(negedge clk);
                b[k] = tx_c;
            end
            repeat (DIV_C) @(negedge clk);
            if (st !== 1'b0 || tx_c !== 1'b1) ferr_c++;
            rx_q.push_back(b);
        end
        prev_c = tx_c;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int unsigned n, t_w, t1;
        logic [7:0]  b, pat;
        logic        ok;
        logic [7:0]  exp_q[$];
        int unsigned target, len;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_en_c = 1'b0;
        wr_data_a = 'x; wr_data_b = 'x; wr_data_c = 'x;
        repeat (3) step();

        // Reset state
        check("a_rst_tx", tx_a, 1);
        check("a_rst_full", full_a, 0);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_wr_err", wr_err_a, 0);
        check("b_rst_tx", tx_b, 1);
        check("b_rst_flags", {full_b, busy_b, wr_err_b}, 0);
        check("c_rst_tx", tx_c, 1);
        check("c_rst_flags", {full_c, busy_c, wr_err_c}, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) step();

        // Single byte 0x55: latency, each level 434 cycles, busy timing
        pat = 8'h55;
        write_byte(0, pat);
        t_w = cyc;
        wait_line(0, 1'b0, 10, n);
        check("a55_latency", cyc - t_w, 2);
        t1 = cyc;
        check("a55_busy_during", busy_a, 1);
        run_len(0, 1000, n);
        check("a55_start_len", n, DIV_A);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a55_bit%0d_val", k), tx_a, pat[k]);
            run_len(0, 1000, n);
            check($sformatf("a55_bit%0d_len", k), n, DIV_A);
        end
        check("a55_stop_val", tx_a, 1);
        wait_idle_a(1000, n);
        check("a55_busy_fall", cyc - t1, 10 * DIV_A);
        check("a55_idle_tx", tx_a, 1);

        // Back-to-back 0xA5, 0x3C
        write_byte(0, 8'hA5);
        t_w = cyc;
        write_byte(0, 8'h3C);
        wait_line(0, 1'b0, 10, n);
        check("a2_latency", cyc - t_w, 2);
        t1 = cyc;
        rx_frame(0, DIV_A, b, ok);
        check("a2_byte0", b, 8'hA5);
        check("a2_frame0_ok", ok, 1);
        wait_line(0, 1'b0, 1000, n);
        check("a2_no_gap", cyc - t1, 10 * DIV_A);
        rx_frame(0, DIV_A, b, ok);
        check("a2_byte1", b, 8'h3C);
        check("a2_frame1_ok", ok, 1);
        wait_idle_a(1000, n);
        check("a2_total", cyc - t1, 20 * DIV_A);

        // Reset 2000 cycles into a 0x0F frame with 3 bytes queued
        write_byte(0, 8'h0F);
        t_w = cyc;
        write_byte(0, 8'h11);
        write_byte(0, 8'h22);
        write_byte(0, 8'h33);
        while (cyc < t_w + 2000) step();
        check("a_rst1_busy_before", busy_a, 1);
        #4;
        rst_a = 1'b1;
        #1;
        check("a_rst1_tx", tx_a, 1);
        check("a_rst1_flags", {full_a, busy_a, wr_err_a}, 0);
        step();
        rst_a = 1'b0;
        wait_line(0, 1'b0, 5000, n);
        check("a_rst1_no_frames", n, 5000);
        check("a_rst1_busy_after", busy_a, 0);
        check("a_rst1_wr_err_after", wr_err_a, 0);

        // First write after reset, then asynchronous abort on a low bit
        write_byte(0, 8'h00);
        t_w = cyc;
        wait_line(0, 1'b0, 10, n);
        check("a_post_rst_latency", cyc - t_w, 2);
        repeat (1000) step();
        check("a_rst2_line_low", tx_a, 0);
        #4;
        rst_a = 1'b1;
        #1;
        check("a_rst2_async_tx", tx_a, 1);
        step();
        rst_a = 1'b0;
        wait_line(0, 1'b0, 1000, n);
        check("a_rst2_no_frames", n, 1000);
        check("a_rst2_busy", busy_a, 0);

        // Override 24 MHz / 9600: bit period 2500
        write_byte(1, 8'h55);
        wait_line(1, 1'b0, 10, n);
        check("b_fall_seen", tx_b, 0);
        run_len(1, 3000, n);
        check("b_start_len", n, DIV_B);
        run_len(1, 3000, n);
        check("b_bit0_len", n, DIV_B);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;

        // 17 writes 0x00..0x10, overflow 0xFF, write on pop at count DEPTH-1
        for (int i = 0; i < 17; i++) begin
            write_byte(2, 8'(i));
            exp_q.push_back(8'(i));
            if (i == 15) check("c_full_at_15", full_c, 0);
            if (i == 16) check("c_full_at_16", full_c, 1);
        end
        write_byte(2, 8'hFF);
        check("c_wr_err_set", wr_err_c, 1);
        check("c_full_held", full_c, 1);
        n = 0;
        while (falls_c < 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("c_second_frame_seen", falls_c, 2);
        check("c_full_cleared", full_c, 0);
        target = last_fall_c + 10 * DIV_C - 2;
        while (cyc < target) @(negedge clk);
        wr_en_c = 1'b1;
        wr_data_c = 8'h5A;
        step();
        wr_en_c = 1'b0;
        wr_data_c = 'x;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        check("c_pop_write_full", full_c, 0);
        n = 0;
        while (rx_q.size() < exp_q.size() && n < 30 * 10 * DIV_C) begin
            @(negedge clk);
            n++;
        end
        check("c_burst_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("c_burst_byte%0d", i), rx_q[i], exp_q[i]);
        end
        repeat (3 * DIV_C) @(negedge clk);
        check("c_burst_idle", busy_c, 0);
        check("c_wr_err_sticky", wr_err_c, 1);
        rst_c = 1'b1;
        step();
        rst_c = 1'b0;
        check("c_wr_err_cleared", wr_err_c, 0);

        // Randomized bursts against the expected byte queue
        rx_q.delete();
        exp_q.delete();
        for (int burst = 0; burst < 6; burst++) begin
            n = 0;
            while (busy_c !== 1'b0 && n < 5000) begin
                step();
                n++;
            end
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < int'(len); i++) begin
                b = 8'($urandom);
                write_byte(2, b);
                exp_q.push_back(b);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        n = 0;
        while (rx_q.size() < exp_q.size() && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("c_rand_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("c_rand_byte%0d", i), rx_q[i], exp_q[i]);
        end
        check("c_framing_errors", ferr_c, 0);
        check("c_rand_wr_err", wr_err_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
